// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address,
// resolves the next PC and registers the fetched word into the IF/ID register.
module fetch_unit #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter int unsigned IM_WORDS   = 4096
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] IMAddr,
    input  logic [31:0] IMOut,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] jr_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc8_D,
    output logic        exc_D,
    output logic [4:0]  exccode_D
);

    // First address past the legal instruction window.
    localparam logic [31:0] IM_LIMIT = IM_BASE + 32'(4 * IM_WORDS);

    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc_d_q;
    logic [31:0] pc8_d_q;
    logic        exc_q;
    logic [4:0]  exccode_q;

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] npc;
    logic        fetch_fault;

    // Next-PC candidates; branch and jump targets come from the instruction now in ID.
    always_comb begin
        pc_plus4  = pc_q + 32'd4;
        br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        br_target = pc_d_q + 32'd4 + br_offset;
        j_target  = {pc_d_q[31:28], instr_q[25:0], 2'b00};
    end

    // Select the next PC from the ID-stage decode.
    always_comb begin
        npc = pc_plus4;
        unique case (npc_sel)
            NPC_SEQ:    npc = pc_plus4;
            NPC_BRANCH: npc = br_taken ? br_target : pc_plus4;
            NPC_JUMP:   npc = j_target;
            NPC_JR:     npc = jr_target;
            default:    npc = pc_plus4;
        endcase
    end

    // AdEL: misaligned or outside the instruction window.
    always_comb begin
        fetch_fault = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q >= IM_LIMIT);
    end

    // PC and IF/ID register update; reset > exc_req > eret > stall > normal advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= PC_RESET;
            instr_q   <= 32'd0;
            pc_d_q    <= PC_RESET;
            pc8_d_q   <= PC_RESET + 32'd8;
            exc_q     <= 1'b0;
            exccode_q <= 5'd0;
        end else if (exc_req) begin
            // Exception overrides stall; IF/ID becomes a nop at the vector.
            pc_q      <= EXC_VECTOR;
            instr_q   <= 32'd0;
            pc_d_q    <= EXC_VECTOR;
            pc8_d_q   <= EXC_VECTOR + 32'd8;
            exc_q     <= 1'b0;
            exccode_q <= 5'd0;
        end else if (eret) begin
            pc_q      <= epc;
            instr_q   <= 32'd0;
            pc_d_q    <= epc;
            pc8_d_q   <= epc + 32'd8;
            exc_q     <= 1'b0;
            exccode_q <= 5'd0;
        end else if (!stall) begin
            // PC keeps advancing on a fault; CP0 raises exc_req later.
            pc_q      <= npc;
            instr_q   <= fetch_fault ? 32'd0 : IMOut;
            pc_d_q    <= pc_q;
            pc8_d_q   <= pc_q + 32'd8;
            exc_q     <= fetch_fault;
            exccode_q <= fetch_fault ? EXC_ADEL : 5'd0;
        end
    end

    // IMAddr comes straight from the PC register, never from npc.
    assign IMAddr    = pc_q;
    assign instr_D   = instr_q;
    assign pc_D      = pc_d_q;
    assign pc8_D     = pc8_d_q;
    assign exc_D     = exc_q;
    assign exccode_D = exccode_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] IMAddr;
    logic [31:0] IMOut;
    logic        stall;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [31:0] jr_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc8_D;
    logic        exc_D;
    logic [4:0]  exccode_D;

    int assert_count = 0;
    int fail_count   = 0;

    fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .IMAddr    (IMAddr),
        .IMOut     (IMOut),
        .stall     (stall),
        .npc_sel   (npc_sel),
        .br_taken  (br_taken),
        .jr_target (jr_target),
        .exc_req   (exc_req),
        .eret      (eret),
        .epc       (epc),
        .instr_D   (instr_D),
        .pc_D      (pc_D),
        .pc8_D     (pc8_D),
        .exc_D     (exc_D),
        .exccode_D (exccode_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: a beq at 0x3010, a j at 0x3020, tagged words elsewhere.
    function automatic logic [31:0] im_word(input logic [31:0] addr);
        if (addr == 32'h0000_3010) return 32'h1000_FFFC;
        if (addr == 32'h0000_3020) return 32'h0800_0C40;
        return {16'hC0DE, addr[15:0]};
    endfunction

    assign IMOut = im_word(IMAddr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                              input logic [31:0] pc, input logic exc);
        check_eq({tag, ".IMAddr"}, IMAddr, addr);
        check_eq({tag, ".instr_D"}, instr_D, instr);
        check_eq({tag, ".pc_D"}, pc_D, pc);
        check_eq({tag, ".pc8_D"}, pc8_D, pc + 32'd8);
        check_eq({tag, ".exc_D"}, {31'd0, exc_D}, {31'd0, exc});
        check_eq({tag, ".exccode_D"}, {27'd0, exccode_D}, exc ? 32'd4 : 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        stall     = 1'b0;
        npc_sel   = 2'b00;
        br_taken  = 1'b0;
        jr_target = 32'd0;
        exc_req   = 1'b0;
        eret      = 1'b0;
        epc       = 32'd0;
        step();
        step();
        check_ifid("reset", 32'h3000, 32'd0, 32'h3000, 1'b0);

        // Sequential fetch
        reset = 1'b0;
        step();
        check_ifid("seq1", 32'h3004, im_word(32'h3000), 32'h3000, 1'b0);
        step();
        check_ifid("seq2", 32'h3008, im_word(32'h3004), 32'h3004, 1'b0);

        // Stall three cycles at 0x3008
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_ifid("stall", 32'h3008, im_word(32'h3004), 32'h3004, 1'b0);
        end
        stall = 1'b0;
        step();
        check_ifid("unstall", 32'h300C, im_word(32'h3008), 32'h3008, 1'b0);

        // Branch back by 4 words from the beq at 0x3010
        step();
        step();
        check_ifid("pre_br", 32'h3014, 32'h1000_FFFC, 32'h3010, 1'b0);
        npc_sel  = 2'b01;
        br_taken = 1'b1;
        step();
        check_ifid("br_taken", 32'h3004, im_word(32'h3014), 32'h3014, 1'b0);
        br_taken = 1'b0;
        step();
        check_ifid("br_not", 32'h3008, im_word(32'h3004), 32'h3004, 1'b0);

        // jr to the j at 0x3020, then j, then jr
        npc_sel   = 2'b11;
        jr_target = 32'h3020;
        step();
        check_eq("jr_3020", IMAddr, 32'h3020);
        npc_sel = 2'b00;
        step();
        check_ifid("pre_j", 32'h3024, 32'h0800_0C40, 32'h3020, 1'b0);
        npc_sel = 2'b10;
        step();
        check_ifid("j", 32'h3100, im_word(32'h3024), 32'h3024, 1'b0);
        npc_sel   = 2'b11;
        jr_target = 32'h3ABC;
        step();
        check_ifid("jr", 32'h3ABC, im_word(32'h3100), 32'h3100, 1'b0);
        npc_sel = 2'b00;

        // Exception during stall, then eret
        stall   = 1'b1;
        exc_req = 1'b1;
        step();
        check_ifid("exc", 32'h4180, 32'd0, 32'h4180, 1'b0);
        stall   = 1'b0;
        exc_req = 1'b0;
        eret    = 1'b1;
        epc     = 32'h3018;
        step();
        check_ifid("eret", 32'h3018, 32'd0, 32'h3018, 1'b0);
        eret = 1'b0;

        // AdEL: misaligned
        npc_sel   = 2'b11;
        jr_target = 32'h3002;
        step();
        check_ifid("to_3002", 32'h3002, im_word(32'h3018), 32'h3018, 1'b0);
        npc_sel = 2'b00;
        step();
        check_ifid("adel_mis", 32'h3006, 32'd0, 32'h3002, 1'b1);

        // AdEL: first address past the window
        npc_sel   = 2'b11;
        jr_target = 32'h7000;
        step();
        npc_sel = 2'b00;
        step();
        check_ifid("adel_hi", 32'h7004, 32'd0, 32'h7000, 1'b1);

        // Last legal word
        npc_sel   = 2'b11;
        jr_target = 32'h6FFC;
        step();
        npc_sel = 2'b00;
        step();
        check_ifid("last_ok", 32'h7000, im_word(32'h6FFC), 32'h6FFC, 1'b0);

        // Reset coincident with exc_req and stall: reset wins
        exc_req = 1'b1;
        stall   = 1'b1;
        reset   = 1'b1;
        step();
        check_ifid("rst_win", 32'h3000, 32'd0, 32'h3000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and drives the instruction memory address. Receives the fetched word back and registers it into the IF/ID pipeline register.
- Resolves next-PC from sequential, branch, jump, jump-register, exception-vector and EPC-return sources. Honours stall and flush from the hazard and CP0 units.
- Flags instruction-fetch address errors (AdEL).

Parameters:
- PC_RESET, 32'h00003000, PC value after reset.
- EXC_VECTOR, 32'h00004180, exception handler entry address.
- IM_BASE, 32'h00003000, lowest legal fetch address.
- IM_WORDS, 4096, number of legal instruction words starting at IM_BASE.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- IMAddr  out  32  fetch address to instruction memory; equals the PC register.
- IMOut  in  32  instruction word returned combinationally for IMAddr.
- stall  in  1  hazard unit stall: hold PC and IF/ID.
- npc_sel  in  2  00 PC+4, 01 branch, 10 j/jal, 11 jr; decoded in ID.
- br_taken  in  1  branch condition true (used only when npc_sel=01).
- jr_target  in  32  register value for jr/jalr.
- exc_req  in  1  CP0 exception/interrupt taken this cycle.
- eret  in  1  eret in ID; redirect to epc.
- epc  in  32  CP0 EPC.
- instr_D  out  32  IF/ID instruction.
- pc_D  out  32  IF/ID PC.
- pc8_D  out  32  IF/ID PC+8, the link address.
- exc_D  out  1  IF/ID AdEL flag.
- exccode_D  out  5  5'd4 when exc_D=1, else 0.

Behaviour:
- Next-PC priority, highest first: reset > exc_req > eret > stall > npc_sel.
- reset: PC←PC_RESET. instr_D, exc_D and exccode_D←0. pc_D←PC_RESET. pc8_D←PC_RESET+8.
- exc_req: PC←EXC_VECTOR. IF/ID flushed: instr_D=0, exc_D=0, pc_D=EXC_VECTOR, pc8_D=EXC_VECTOR+8. Overrides stall.
- eret (no exc_req): PC←epc. IF/ID flushed to a nop, the same as for exc_req, with pc_D=epc.
- stall (no exc_req/eret): PC and all IF/ID registers hold their value.
- Otherwise PC←npc, and IF/ID loads {IMOut or 0, PC, PC+8, fault}.
- npc computation (no delay-slot flush; the delay slot always executes):
  - 00, or 01 with br_taken=0: PC+4.
  - 01 with br_taken=1: pc_D+4+(sign_extend(instr_D[15:0])<<2), 32-bit wraparound.
  - 10: {pc_D[31:28], instr_D[25:0], 2'b00}.
  - 11: jr_target.
- Fault detect (combinational on PC):
  - Fault when PC[1:0]≠0, PC<IM_BASE, or PC≥IM_BASE+4*IM_WORDS (default 0x7000).
  - On fault, IF/ID loads instr=0 (nop), exc_D=1, exccode_D=4, and pc_D=faulting PC.
  - The PC still advances per npc; CP0 raises exc_req later.
- Latency: an instruction at PC appears on instr_D one cycle after PC is presented, if not stalled.
- IMAddr is driven directly from the PC register, never from npc, so there is no combinational path from stall/npc_sel to IMAddr.
- Reset asserted mid-stall or coincident with exc_req: reset wins on that edge.
- Unknown npc_sel cannot occur; all four codes are defined.

Test Plan:
- Reset, then release with npc_sel=00 and no stall.
  - IMAddr=0x3000, 0x3004, 0x3008 on successive cycles.
  - instr_D/pc_D lag IMAddr by one cycle.
  - pc8_D=pc_D+8.
- Branch redirect: pc_D=0x3010, instr_D[15:0]=16'hFFFC, npc_sel=01, br_taken=1.
  - Next IMAddr=0x3004.
  - The delay-slot instruction at 0x3014 still reaches instr_D.
  - With br_taken=0, next IMAddr=PC+4.
- Jump redirects.
  - j with pc_D=0x3020, instr_D[25:0]=26'h0000C40: next IMAddr=0x3100.
  - jr with jr_target=0x3ABC: next IMAddr=0x3ABC.
- Stall for 3 cycles at IMAddr=0x3008: IMAddr and IF/ID are unchanged for 3 cycles, then advance to 0x300C.
- exc_req asserted during stall: next IMAddr=0x4180, instr_D=0, exc_D=0.
  - Then eret with epc=0x3018: next IMAddr=0x3018 and IF/ID holds a nop.
- AdEL faults.
  - jr_target=0x3002: exc_D=1, exccode_D=4, instr_D=0, pc_D=0x3002 one cycle after the fetch.
  - jr_target=0x7000: same response.
  - jr_target=0x6FFC: no fault.
